nts_api_master: RTL

NTS_API_MASTER -- requirements
Module: nts_api_master

---
 rtl/nts_api_master.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/nts_api_master.sv
`default_nettype none
// ============================================================================
// Module      : nts_api_master
// Description : Single-outstanding request/response bridge onto the NTS engine
//               API. A request is captured in IDLE, issued as a one-cycle chip
//               select, and its completion is returned on a held response
//               channel.
//               Optional feature macro: NTS_API_MASTER_TIMEOUT_EN abandons
//               a transaction after TIMEOUT_CYCLES WAIT cycles and reports
//               o_rsp_error.
// Revision    : 1.0 - initial release
// ============================================================================
module nts_api_master #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic        i_clk,
    input  logic        i_areset_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [11:0] i_req_address,
    input  logic [31:0] i_req_write_data,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_read_data,
    output logic        o_rsp_error,
    output logic        o_api_cs,
    output logic        o_api_we,
    output logic [11:0] o_api_address,
    output logic [31:0] o_api_write_data,
    input  logic [31:0] i_api_read_data,
    input  logic        i_api_read_data_valid,
    input  logic        i_api_busy,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        accept;
    logic        complete;
    logic        expire;
    logic        api_we_q;
    logic [11:0] api_address_q;
    logic [31:0] api_write_data_q;
    logic [31:0] rsp_read_data_q;

    // Ready is gated by reset so the requester sees 0 while reset is held.
    assign o_req_ready = i_areset_n && (state == ST_IDLE) && !i_api_busy;
    assign accept      = (state == ST_IDLE) && i_req_valid && !i_api_busy;
    assign complete    = (state == ST_WAIT) && i_api_read_data_valid;

    assign o_busy           = (state != ST_IDLE);
    assign o_api_cs         = (state == ST_ISSUE);
    assign o_rsp_valid      = (state == ST_RESP);
    assign o_api_we         = api_we_q;
    assign o_api_address    = api_address_q;
    assign o_api_write_data = api_write_data_q;
    assign o_rsp_read_data  = rsp_read_data_q;

`ifdef NTS_API_MASTER_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        rsp_error_q;

    // Count WAIT cycles; cleared in ISSUE so it reads 0 on the first WAIT cycle.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            wait_cnt <= 16'd0;
        end else if (state == ST_ISSUE) begin
            wait_cnt <= 16'd0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    // Expiry on the last allowed WAIT cycle; a completion in that cycle wins.
    assign expire = (state == ST_WAIT) && !i_api_read_data_valid &&
                    (wait_cnt == (TIMEOUT_CYCLES - 16'd1));

    // Error flag is latched alongside the response data.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            rsp_error_q <= 1'b0;
        end else if (complete) begin
            rsp_error_q <= 1'b0;
        end else if (expire) begin
            rsp_error_q <= 1'b1;
        end
    end

    assign o_rsp_error = rsp_error_q;
`else
    assign expire      = 1'b0;
    assign o_rsp_error = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (accept) next_state = ST_ISSUE;
            ST_ISSUE: next_state = ST_WAIT;
            ST_WAIT:  if (complete || expire) next_state = ST_RESP;
            ST_RESP:  if (i_rsp_ready) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Capture the request; the API bus holds these until the next acceptance.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            api_we_q         <= 1'b0;
            api_address_q    <= 12'd0;
            api_write_data_q <= 32'd0;
        end else if (accept) begin
            api_we_q         <= i_req_we;
            api_address_q    <= i_req_address;
            api_write_data_q <= i_req_write_data;
        end
    end

    // Response data: read data for reads, zero for writes and timeouts.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            rsp_read_data_q <= 32'd0;
        end else if (complete) begin
            rsp_read_data_q <= api_we_q ? 32'd0 : i_api_read_data;
        end else if (expire) begin
            rsp_read_data_q <= 32'd0;
        end
    end

endmodule
`default_nettype wire
